// File: rtl/obstacle_pkg.sv
// Shared types and constants for the frame-synchronous obstacle selector.
// Obstacle word layout is {obstacle_x, obstacle_y, rgb}, MSB first.
package obstacle_pkg;

   localparam int unsigned X_W     = 12;
   localparam int unsigned Y_W     = 12;
   localparam int unsigned RGB_W   = 12;
   localparam int unsigned OBST_W  = X_W + Y_W + RGB_W;
   localparam int unsigned RGB_OFF = 0;
   localparam int unsigned Y_OFF   = RGB_W;
   localparam int unsigned X_OFF   = RGB_W + Y_W;

   typedef struct packed {
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic [RGB_W-1:0] rgb;
   } obstacle_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      BLANK   = 2'd2
   } sel_state_e;

   localparam obstacle_t BLANK_WORD_DEF = '0;

   // Width of a channel index; a single-channel select still needs one bit.
   function automatic int unsigned sel_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Width of the blank-frame counter, able to hold the value n.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n == 0) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/obstacle_sel_sync_if.sv
// Select request/acknowledge handshake between a controller and the selector.
interface obstacle_sel_sync_if #(
   parameter int unsigned SW = 3
);
   logic          sel_req;
   logic [SW-1:0] sel_id;
   logic          sel_ready;
   logic          sel_ack;
   logic          sel_err;

   modport master (
      output sel_req,
      output sel_id,
      input  sel_ready,
      input  sel_ack,
      input  sel_err
   );

   modport slave (
      input  sel_req,
      input  sel_id,
      output sel_ready,
      output sel_ack,
      output sel_err
   );
endinterface

// File: rtl/obstacle_sel_fsm.sv
// Select handshake and frame-boundary switch controller: owns active_sel,
// the pending channel and the post-switch blanking counter.
module obstacle_sel_fsm
   import obstacle_pkg::*;
#(
   parameter  int unsigned NCH          = 7,
   parameter  int unsigned BLANK_FRAMES = 1,
   parameter  int unsigned RESET_SEL    = 0,
   localparam int unsigned SW           = sel_w(NCH)
) (
   input  logic                  pclk,
   input  logic                  rst,
   input  logic                  frame_start,
   obstacle_sel_sync_if.slave    sel_bus,
   output logic [SW-1:0]         active_sel,
   output logic                  blanking
);

   localparam int unsigned BCW = cnt_w(BLANK_FRAMES);

   sel_state_e     r_state;
   logic [SW-1:0]  r_pending;
   logic [BCW-1:0] r_blank_cnt;
   logic [SW-1:0]  r_active_sel;
   logic           r_blanking;
   logic           r_ack;
   logic           r_err;

   sel_state_e     w_state_nxt;
   logic [SW-1:0]  w_pending_nxt;
   logic [BCW-1:0] w_blank_cnt_nxt;
   logic [SW-1:0]  w_active_sel_nxt;
   logic           w_blanking_nxt;
   logic           w_ack_nxt;
   logic           w_err_nxt;
   logic           w_id_valid;

   // Compare one bit wider so a power-of-two NCH stays a legal comparison.
   assign w_id_valid = ({1'b0, sel_bus.sel_id} < (SW + 1)'(NCH));

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_pending    <= '0;
         r_blank_cnt  <= '0;
         r_active_sel <= SW'(RESET_SEL);
         r_blanking   <= 1'b0;
         r_ack        <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pending    <= w_pending_nxt;
         r_blank_cnt  <= w_blank_cnt_nxt;
         r_active_sel <= w_active_sel_nxt;
         r_blanking   <= w_blanking_nxt;
         r_ack        <= w_ack_nxt;
         r_err        <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pending_nxt    = r_pending;
      w_blank_cnt_nxt  = r_blank_cnt;
      w_active_sel_nxt = r_active_sel;
      w_blanking_nxt   = r_blanking;
      w_ack_nxt        = 1'b0;
      w_err_nxt        = 1'b0;

      case (r_state)
         IDLE: begin
            // A frame_start in the same cycle as acceptance does not switch.
            if (sel_bus.sel_req) begin
               if (w_id_valid) begin
                  w_pending_nxt = sel_bus.sel_id;
                  w_ack_nxt     = 1'b1;
                  w_state_nxt   = PENDING;
               end else begin
                  w_err_nxt     = 1'b1;
               end
            end
         end

         PENDING: begin
            if (frame_start) begin
               w_active_sel_nxt = r_pending;
               if (BLANK_FRAMES == 0) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_blank_cnt_nxt = BCW'(BLANK_FRAMES);
                  w_blanking_nxt  = 1'b1;
                  w_state_nxt     = BLANK;
               end
            end
         end

         BLANK: begin
            if (frame_start) begin
               if (r_blank_cnt <= BCW'(1)) begin
                  w_blank_cnt_nxt = '0;
                  w_blanking_nxt  = 1'b0;
                  w_state_nxt     = IDLE;
               end else begin
                  w_blank_cnt_nxt = r_blank_cnt - BCW'(1);
               end
            end
         end

         default: begin
            w_blanking_nxt = 1'b0;
            w_state_nxt    = IDLE;
         end
      endcase
   end

   assign sel_bus.sel_ready = (r_state == IDLE);
   assign sel_bus.sel_ack   = r_ack;
   assign sel_bus.sel_err   = r_err;
   assign active_sel        = r_active_sel;
   assign blanking          = r_blanking;

endmodule

// File: rtl/obstacle_sel_sync.sv
// Frame-synchronous obstacle selector: registered NCH-to-1 word mux whose
// channel changes only at frame boundaries, with optional post-switch blanking.
module obstacle_sel_sync
   import obstacle_pkg::*;
#(
   parameter  int unsigned NCH          = 7,
   parameter  int unsigned W            = OBST_W,
   parameter  int unsigned BLANK_FRAMES = 1,
   parameter  logic [W-1:0] BLANK_VALUE = W'(BLANK_WORD_DEF),
   parameter  int unsigned RESET_SEL    = 0,
   localparam int unsigned SW           = sel_w(NCH)
) (
   input  logic                  pclk,
   input  logic                  rst,
   input  logic [NCH*W-1:0]      ch_in,
   input  logic                  frame_start,
   obstacle_sel_sync_if.slave    sel_bus,
   output logic [SW-1:0]         active_sel,
   output logic                  blanking,
   output logic [W-1:0]          mux_out
);

   logic [W-1:0] r_mux_out;
   logic [W-1:0] w_sel_word;

   obstacle_sel_fsm #(
      .NCH          (NCH),
      .BLANK_FRAMES (BLANK_FRAMES),
      .RESET_SEL    (RESET_SEL)
   ) u_fsm (
      .pclk        (pclk),
      .rst         (rst),
      .frame_start (frame_start),
      .sel_bus     (sel_bus),
      .active_sel  (active_sel),
      .blanking    (blanking)
   );

   // Channel slice picked by the registered active_sel only.
   always_comb begin
      w_sel_word = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         if (active_sel == SW'(k)) begin
            w_sel_word = ch_in[k*W +: W];
         end
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_mux_out <= '0;
      end else begin
         r_mux_out <= blanking ? BLANK_VALUE : w_sel_word;
      end
   end

   assign mux_out = r_mux_out;

endmodule

// File: tb/tb_obstacle_sel_sync.sv
// Directed bench for obstacle_sel_sync: three configurations (no blanking,
// two-frame blanking, 16 x 24-bit channels) sharing one clock and reset.
module tb_obstacle_sel_sync;

   localparam logic [35:0] BV_B = 36'hFFF000000;

   logic pclk = 1'b0;
   logic rst  = 1'b0;
   logic fs   = 1'b0;

   logic [7*36-1:0]  ch7;
   logic [16*24-1:0] chc;
   logic [23:0]      cw [16];

   logic [2:0]  act_a, act_b;
   logic [3:0]  act_c;
   logic        blk_a, blk_b, blk_c;
   logic [35:0] mux_a, mux_b;
   logic [23:0] mux_c;

   int n_checks = 0;
   int n_errors = 0;

   obstacle_sel_sync_if #(.SW(3)) bus_a ();
   obstacle_sel_sync_if #(.SW(3)) bus_b ();
   obstacle_sel_sync_if #(.SW(4)) bus_c ();

   obstacle_sel_sync #(.NCH(7), .W(36), .BLANK_FRAMES(0), .BLANK_VALUE(36'h0), .RESET_SEL(0)) dut_a (
      .pclk(pclk), .rst(rst), .ch_in(ch7), .frame_start(fs), .sel_bus(bus_a),
      .active_sel(act_a), .blanking(blk_a), .mux_out(mux_a));

   obstacle_sel_sync #(.NCH(7), .W(36), .BLANK_FRAMES(2), .BLANK_VALUE(BV_B), .RESET_SEL(0)) dut_b (
      .pclk(pclk), .rst(rst), .ch_in(ch7), .frame_start(fs), .sel_bus(bus_b),
      .active_sel(act_b), .blanking(blk_b), .mux_out(mux_b));

   obstacle_sel_sync #(.NCH(16), .W(24), .BLANK_FRAMES(1), .BLANK_VALUE(24'h0), .RESET_SEL(0)) dut_c (
      .pclk(pclk), .rst(rst), .ch_in(chc), .frame_start(fs), .sel_bus(bus_c),
      .active_sel(act_c), .blanking(blk_c), .mux_out(mux_c));

   always #5 pclk = ~pclk;

   typedef struct {
      logic        req;
      logic [2:0]  id;
      logic        fs;
      logic        e_ready;
      logic        e_ack;
      logic        e_err;
      logic [2:0]  e_act;
      logic [35:0] e_mux;
   } vec_t;

   vec_t vt [15];

   function automatic logic [35:0] chw(input int k);
      return {12'(k*16 + 1), 12'(k*16 + 2), 12'(k*16 + 3)};
   endfunction

   function automatic vec_t mkv(input logic req, input logic [2:0] id, input logic f,
                                input logic rdy, input logic ack, input logic err,
                                input logic [2:0] act, input logic [35:0] mx);
      vec_t v;
      v.req = req; v.id = id; v.fs = f;
      v.e_ready = rdy; v.e_ack = ack; v.e_err = err; v.e_act = act; v.e_mux = mx;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 7; k++) ch7[k*36 +: 36] = chw(k);
      for (int k = 0; k < 16; k++) begin
         cw[k] = 24'($urandom);
         chc[k*24 +: 24] = cw[k];
      end
      bus_a.sel_req = 1'b0; bus_a.sel_id = '0;
      bus_b.sel_req = 1'b0; bus_b.sel_id = '0;
      bus_c.sel_req = 1'b0; bus_c.sel_id = '0;

      // Switch table for the unblanked instance; each row is sampled after one edge.
      vt[0]  = mkv(0, 3'd0, 0, 1, 0, 0, 3'd0, chw(0));
      vt[1]  = mkv(1, 3'd3, 0, 0, 1, 0, 3'd0, chw(0));
      vt[2]  = mkv(0, 3'd0, 0, 0, 0, 0, 3'd0, chw(0));
      vt[3]  = mkv(1, 3'd5, 0, 0, 0, 0, 3'd0, chw(0));
      vt[4]  = mkv(0, 3'd0, 1, 1, 0, 0, 3'd3, chw(0));
      vt[5]  = mkv(0, 3'd0, 0, 1, 0, 0, 3'd3, chw(3));
      vt[6]  = mkv(1, 3'd7, 0, 1, 0, 1, 3'd3, chw(3));
      vt[7]  = mkv(0, 3'd0, 0, 1, 0, 0, 3'd3, chw(3));
      vt[8]  = mkv(1, 3'd2, 1, 0, 1, 0, 3'd3, chw(3));
      vt[9]  = mkv(0, 3'd0, 0, 0, 0, 0, 3'd3, chw(3));
      vt[10] = mkv(0, 3'd0, 1, 1, 0, 0, 3'd2, chw(3));
      vt[11] = mkv(0, 3'd0, 0, 1, 0, 0, 3'd2, chw(2));
      vt[12] = mkv(1, 3'd6, 0, 0, 1, 0, 3'd2, chw(2));
      vt[13] = mkv(0, 3'd0, 1, 1, 0, 0, 3'd6, chw(2));
      vt[14] = mkv(0, 3'd0, 0, 1, 0, 0, 3'd6, chw(6));

      // Reset state
      #2 rst = 1'b1;
      #2;
      chk("rst_act_a", 64'(act_a), 64'd0);
      chk("rst_mux_a", 64'(mux_a), 64'd0);
      chk("rst_ready_a", 64'(bus_a.sel_ready), 64'd1);
      chk("rst_blank_a", 64'(blk_a), 64'd0);
      chk("rst_ack_a", 64'(bus_a.sel_ack), 64'd0);
      chk("rst_err_a", 64'(bus_a.sel_err), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("post_rst_mux_a", 64'(mux_a), 64'(chw(0)));

      for (int i = 0; i < 15; i++) begin
         bus_a.sel_req = vt[i].req;
         bus_a.sel_id  = vt[i].id;
         fs            = vt[i].fs;
         tick();
         chk($sformatf("vec%0d_ready", i), 64'(bus_a.sel_ready), 64'(vt[i].e_ready));
         chk($sformatf("vec%0d_ack", i),   64'(bus_a.sel_ack),   64'(vt[i].e_ack));
         chk($sformatf("vec%0d_err", i),   64'(bus_a.sel_err),   64'(vt[i].e_err));
         chk($sformatf("vec%0d_act", i),   64'(act_a),           64'(vt[i].e_act));
         chk($sformatf("vec%0d_blank", i), 64'(blk_a),           64'd0);
         chk($sformatf("vec%0d_mux", i),   64'(mux_a),           64'(vt[i].e_mux));
      end
      bus_a.sel_req = 1'b0;
      fs = 1'b0;

      // Two-frame blanking after a switch to channel 5
      bus_b.sel_req = 1'b1; bus_b.sel_id = 3'd5;
      tick();
      bus_b.sel_req = 1'b0;
      chk("b_ack", 64'(bus_b.sel_ack), 64'd1);
      chk("b_ready_pend", 64'(bus_b.sel_ready), 64'd0);
      tick();
      chk("b_act_before_fs", 64'(act_b), 64'd0);
      fs = 1'b1; tick(); fs = 1'b0;
      chk("b_act_switched", 64'(act_b), 64'd5);
      chk("b_blank_on", 64'(blk_b), 64'd1);
      chk("b_mux_old_word", 64'(mux_b), 64'(chw(0)));
      tick();
      chk("b_mux_blank1", 64'(mux_b), 64'(BV_B));
      bus_b.sel_req = 1'b1; bus_b.sel_id = 3'd1;
      tick();
      bus_b.sel_req = 1'b0;
      chk("b_req_in_blank_ack", 64'(bus_b.sel_ack), 64'd0);
      chk("b_req_in_blank_err", 64'(bus_b.sel_err), 64'd0);
      chk("b_ready_blank", 64'(bus_b.sel_ready), 64'd0);
      repeat (3) tick();
      chk("b_mux_blank2", 64'(mux_b), 64'(BV_B));
      fs = 1'b1; tick(); fs = 1'b0;
      chk("b_blank_frame2", 64'(blk_b), 64'd1);
      chk("b_ready_frame2", 64'(bus_b.sel_ready), 64'd0);
      tick();
      chk("b_mux_blank3", 64'(mux_b), 64'(BV_B));
      fs = 1'b1; tick(); fs = 1'b0;
      chk("b_blank_off", 64'(blk_b), 64'd0);
      chk("b_ready_back", 64'(bus_b.sel_ready), 64'd1);
      chk("b_mux_last_blank", 64'(mux_b), 64'(BV_B));
      tick();
      chk("b_mux_ch5", 64'(mux_b), 64'(chw(5)));
      chk("b_act_kept", 64'(act_b), 64'd5);

      // Reset while a request is pending discards it
      bus_b.sel_req = 1'b1; bus_b.sel_id = 3'd4;
      tick();
      bus_b.sel_req = 1'b0;
      chk("b_ack2", 64'(bus_b.sel_ack), 64'd1);
      tick();
      rst = 1'b1;
      #1;
      chk("b_rst_act", 64'(act_b), 64'd0);
      chk("b_rst_mux", 64'(mux_b), 64'd0);
      chk("b_rst_ready", 64'(bus_b.sel_ready), 64'd1);
      chk("b_rst_blank", 64'(blk_b), 64'd0);
      tick();
      rst = 1'b0;
      fs = 1'b1; tick(); fs = 1'b0;
      chk("b_no_stale_switch", 64'(act_b), 64'd0);
      chk("b_no_stale_blank", 64'(blk_b), 64'd0);
      tick();
      chk("b_post_rst_mux", 64'(mux_b), 64'(chw(0)));

      // Every channel of the 16 x 24-bit instance, one-frame blanking each
      for (int k = 0; k < 16; k++) begin
         bus_c.sel_req = 1'b1; bus_c.sel_id = 4'(k);
         tick();
         bus_c.sel_req = 1'b0;
         chk($sformatf("c%0d_ack", k), 64'(bus_c.sel_ack), 64'd1);
         fs = 1'b1; tick(); fs = 1'b0;
         chk($sformatf("c%0d_act", k), 64'(act_c), 64'(k));
         chk($sformatf("c%0d_blank", k), 64'(blk_c), 64'd1);
         tick();
         chk($sformatf("c%0d_mux_blank", k), 64'(mux_c), 64'd0);
         fs = 1'b1; tick(); fs = 1'b0;
         chk($sformatf("c%0d_unblank", k), 64'(blk_c), 64'd0);
         tick();
         chk($sformatf("c%0d_mux", k), 64'(mux_c), 64'(cw[k]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/obstacle_sel_sync.md
Name: obstacle_sel_sync

Overview:
- Parametrised, registered successor to the 7-to-1 obstacle mux.
- Selects one of NCH packed obstacle words {obstacle_x, obstacle_y, rgb} for the draw pipeline.
- Channel changes are requested through a req/ack handshake and take effect only at a frame boundary, so no frame ever shows a torn obstacle.
- After a switch, it can blank the output for a programmable number of frames.

Parameters:
- NCH, 7: number of input channels, 2..16.
- W, 36: width of one obstacle word.
- BLANK_FRAMES, 1: frames of blanking after each switch; 0 means no blanking.
- BLANK_VALUE, 0: W-bit word driven on mux_out while blanking.
- RESET_SEL, 0: channel active after reset; must be < NCH.
- SW (localparam): $clog2(NCH), minimum 1.

Ports:
- pclk, in, 1: pixel clock; the only clock.
- rst, in, 1: asynchronous, active-high reset.
- ch_in, in, NCH*W: channel k occupies bits [k*W +: W].
- frame_start, in, 1: single-cycle pulse at start of frame (vsync edge), synchronous to pclk.
- sel_req, in, 1: select request, qualified by sel_ready.
- sel_id, in, SW: requested channel.
- sel_ready, out, 1: request can be accepted this cycle.
- sel_ack, out, 1: one-cycle pulse; request accepted.
- sel_err, out, 1: one-cycle pulse; request rejected because sel_id >= NCH.
- active_sel, out, SW: channel currently driving mux_out.
- blanking, out, 1: high while BLANK_VALUE is substituted.
- mux_out, out, W: registered selected obstacle word.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, active_sel=RESET_SEL, pending=0, blank_cnt=0.
  - mux_out=0, sel_ack=0, sel_err=0, blanking=0.
  - A reset mid-request or mid-blank discards all pending work.
- FSM states: IDLE, PENDING, BLANK.
- sel_ready = (state==IDLE). It is combinational from state only.
- IDLE:
  - If sel_req and sel_id<NCH: pending<=sel_id, sel_ack=1 next cycle, go to PENDING.
  - If sel_req and sel_id>=NCH: sel_err=1 next cycle; no state change, no ack.
  - A sel_req coinciding with frame_start is accepted normally. The switch happens at the NEXT frame_start, never the same one.
- PENDING:
  - sel_req is ignored (ready=0); no ack and no err.
  - On frame_start: active_sel<=pending.
  - If BLANK_FRAMES==0, go to IDLE; else blank_cnt<=BLANK_FRAMES, blanking<=1, go to BLANK.
- BLANK:
  - On each frame_start, blank_cnt decrements.
  - On frame_start with blank_cnt==1: blanking<=0, go to IDLE.
  - Blanking therefore covers exactly BLANK_FRAMES whole frames.
- A request for the channel already active is handled like any other: full switch sequence, including blanking.
- Datapath, one-cycle latency:
  - mux_out(t+1) = blanking(t) ? BLANK_VALUE : ch_in[active_sel(t)*W +: W].
  - The first new-channel (or BLANK_VALUE) word appears one edge after the frame_start edge that performed the switch.
- blank_cnt width is $clog2(BLANK_FRAMES+1), minimum 1. Never decrement below 0.
- No combinational path from ch_in to mux_out. sel_ack and sel_err are mutually exclusive.

Decomposition:
- Shared package obstacle_pkg holds:
  - OBST_W=36, with X_W=12, Y_W=12, RGB_W=12 field widths and offsets.
  - The FSM state encoding (IDLE=2'd0, PENDING=2'd1, BLANK=2'd2).
  - A default blank-word constant.
- One sub-module: obstacle_sel_fsm, containing the handshake, the FSM, blank_cnt and active_sel.
- The top level keeps only the indexed, registered datapath.

Test Plan:
- Reset: rst high mid-PENDING -> immediately active_sel=0, mux_out=0, sel_ready=1, blanking=0. After release, mux_out = ch_in[0] on the second edge.
- Basic switch (NCH=7, BLANK_FRAMES=0): sel_req with sel_id=3 in IDLE -> sel_ack one cycle later. active_sel stays 0 until frame_start; mux_out=ch_in[3] one edge after the frame_start edge.
- Blanking (BLANK_FRAMES=2, BLANK_VALUE=36'hFFF000000): switch to channel 5 -> mux_out=BLANK_VALUE for exactly 2 frame_start intervals, then ch_in[5]. sel_ready returns high at the 2nd frame_start after the switch.
- Invalid id: sel_id=7 with NCH=7 -> sel_err pulse, no sel_ack, active_sel unchanged, state IDLE.
- Contention: sel_req with sel_id=2 and frame_start in the same cycle in IDLE -> ack, no switch. Switch occurs at the following frame_start. A sel_req during PENDING or BLANK produces no ack and no err.
- Generalisation: NCH=16, W=24, random ch_in -> every valid sel_id 0..15 routes the correct 24-bit slice after its frame_start.
